// File: rtl/dna_pkg.sv
// Shared types for the DNA stream searcher: 2-bit nucleotide encoding and search FSM states.
package dna_pkg;

    typedef enum logic [1:0] {
        NUC_A = 2'b00,
        NUC_C = 2'b01,
        NUC_G = 2'b10,
        NUC_T = 2'b11
    } nuc_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } search_state_t;

endpackage

// File: rtl/dna_window_match.sv
// Sliding nucleotide window with saturating fill count; compares the newest pat_len symbols
// (the incoming nuc_i included) against a pattern whose symbol 0 is the oldest.
module dna_window_match
    import dna_pkg::*;
#(
    parameter int MAX_PAT = 8,
    parameter int PL_W    = $clog2(MAX_PAT + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear_i,
    input  logic                 shift_i,
    input  nuc_t                 nuc_i,
    input  logic [2*MAX_PAT-1:0] pattern_i,
    input  logic [PL_W-1:0]      pat_len_i,
    output logic                 match_o
);

    localparam int IDX_W = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;

    nuc_t             win_q [MAX_PAT];  // win_q[0] holds the most recently shifted symbol
    logic [PL_W-1:0]  fill_q;
    nuc_t             cand  [MAX_PAT];
    logic [IDX_W-1:0] idx;

    // NOTE: the window is a few flops rather than a RAM, so it takes the reset like any other state.
    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            for (int k = 0; k < MAX_PAT; k++) win_q[k] <= NUC_A;
            fill_q <= '0;
        end else if (shift_i) begin
            win_q[0] <= nuc_i;
            for (int k = 1; k < MAX_PAT; k++) win_q[k] <= win_q[k-1];
            if (int'(fill_q) < MAX_PAT) fill_q <= fill_q + 1'b1;
        end
    end

    // NOTE: every variable gets its default before any conditional update, so no latch is inferred.
    always_comb begin
        cand[0] = nuc_i;
        for (int k = 1; k < MAX_PAT; k++) cand[k] = win_q[k-1];
        idx     = '0;
        match_o = (pat_len_i != '0) && (int'(fill_q) + 1 >= int'(pat_len_i));
        for (int j = 0; j < MAX_PAT; j++) begin
            if (j < int'(pat_len_i)) begin
                idx = IDX_W'(int'(pat_len_i) - 1 - j);
                if (pattern_i[2*j +: 2] != cand[idx]) match_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dna_stream_search.sv
// Streaming DNA pattern searcher over a 1-cycle-latency sequence memory; reports the first match.
// Optional feature macro DNA_SEARCH_COUNT_EN: scan to the end and count every (overlapping) match.
module dna_stream_search
    import dna_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MAX_PAT = 8,
    parameter int CNT_W   = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         ready,
    input  logic [ADDR_W-1:0]            dna_start,
    input  logic [ADDR_W-1:0]            dna_length,
    input  logic [2*MAX_PAT-1:0]         pattern,
    input  logic [$clog2(MAX_PAT+1)-1:0] pat_len,
    output logic                         seq_re,
    output logic [ADDR_W-1:0]            seq_addr,
    input  logic [1:0]                   seq_data,
    output logic                         done,
    output logic                         found_it,
    output logic                         error,
    output logic [ADDR_W-1:0]            match_pos
`ifdef DNA_SEARCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]             match_count
`endif
);

    localparam int PL_W = $clog2(MAX_PAT + 1);

    search_state_t        state_q;
    logic [ADDR_W-1:0]    start_q;
    logic [ADDR_W-1:0]    len_q;
    logic [ADDR_W-1:0]    issued_q;
    logic [ADDR_W-1:0]    arr_idx_q;
    logic [ADDR_W-1:0]    seq_addr_q;
    logic [ADDR_W-1:0]    match_pos_q;
    logic [2*MAX_PAT-1:0] pat_q;
    logic [PL_W-1:0]      pat_len_q;
    logic                 seq_re_q;
    logic                 rd_valid_q;
    logic                 done_q;
    logic                 found_q;
    logic                 error_q;

    logic                 accept;
    logic                 req_bad;
    logic [ADDR_W:0]      req_end;
    logic                 win_match;
    logic                 last_nuc;
    logic                 stop_now;
    logic [ADDR_W-1:0]    match_pos_d;

    assign accept  = ready && (state_q == S_IDLE || state_q == S_DONE);
    assign req_end = {1'b0, dna_start} + {1'b0, dna_length};
    assign req_bad = (pat_len == '0)
                  || (int'(pat_len) > MAX_PAT)
                  || ({{ADDR_W{1'b0}}, pat_len} > {{PL_W{1'b0}}, dna_length})
                  || (req_end > {1'b1, {ADDR_W{1'b0}}});

    // arr_idx_q is the index of the nucleotide currently on seq_data.
    assign last_nuc    = (arr_idx_q == len_q - 1'b1);
    assign match_pos_d = start_q + arr_idx_q + ADDR_W'(1) - ADDR_W'(pat_len_q);

`ifdef DNA_SEARCH_COUNT_EN
    assign stop_now = rd_valid_q && last_nuc;
`else
    assign stop_now = rd_valid_q && (last_nuc || win_match);
`endif

    dna_window_match #(
        .MAX_PAT (MAX_PAT),
        .PL_W    (PL_W)
    ) u_window (
        .clock     (clock),
        .reset     (reset),
        .clear_i   (accept),
        .shift_i   (rd_valid_q),
        .nuc_i     (nuc_t'(seq_data)),
        .pattern_i (pat_q),
        .pat_len_i (pat_len_q),
        .match_o   (win_match)
    );

    // NOTE: all state here uses <= so every register is computed from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            start_q     <= '0;
            len_q       <= '0;
            pat_q       <= '0;
            pat_len_q   <= '0;
            issued_q    <= '0;
            arr_idx_q   <= '0;
            seq_addr_q  <= '0;
            seq_re_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            error_q     <= 1'b0;
            match_pos_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        start_q     <= dna_start;
                        len_q       <= dna_length;
                        pat_q       <= pattern;
                        pat_len_q   <= pat_len;
                        issued_q    <= ADDR_W'(1);
                        arr_idx_q   <= '0;
                        seq_addr_q  <= dna_start;
                        rd_valid_q  <= 1'b0;
                        found_q     <= 1'b0;
                        match_pos_q <= '0;
                        done_q      <= req_bad;
                        error_q     <= req_bad;
                        seq_re_q    <= !req_bad;
                        state_q     <= req_bad ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (issued_q != len_q) begin
                        seq_addr_q <= seq_addr_q + 1'b1;
                        issued_q   <= issued_q + 1'b1;
                    end else begin
                        seq_re_q <= 1'b0;
                    end
                    rd_valid_q <= seq_re_q;
                    if (rd_valid_q) arr_idx_q <= arr_idx_q + 1'b1;
                    if (rd_valid_q && win_match && !found_q) begin
                        found_q     <= 1'b1;
                        match_pos_q <= match_pos_d;
                    end
                    // Reads still in flight when the search stops are simply never looked at.
                    if (stop_now) begin
                        state_q    <= S_DONE;
                        done_q     <= 1'b1;
                        seq_re_q   <= 1'b0;
                        rd_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef DNA_SEARCH_COUNT_EN
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock) begin
        if (reset || accept) begin
            count_q <= '0;
        end else if (state_q == S_RUN && rd_valid_q && win_match && count_q != '1) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign match_count = count_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

    assign seq_re    = seq_re_q;
    assign seq_addr  = seq_addr_q;
    assign done      = done_q;
    assign found_it  = found_q;
    assign error     = error_q;
    assign match_pos = match_pos_q;

endmodule

// File: tb/tb_dna_stream_search.sv
// Bench for dna_stream_search: a table of searches scored through an expected-result queue,
// plus hand-written reset-mid-run and ready-during-run sequences.
`timescale 1ns/1ps
module tb_dna_stream_search;

    localparam int ADDR_W  = 16;
    localparam int MAX_PAT = 8;
    localparam int CNT_W   = 8;
    localparam int PL_W    = 4;
`ifdef DNA_SEARCH_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 ready = 1'b0;
    logic [ADDR_W-1:0]    dna_start = '0;
    logic [ADDR_W-1:0]    dna_length = '0;
    logic [2*MAX_PAT-1:0] pattern = '0;
    logic [PL_W-1:0]      pat_len = '0;
    logic                 seq_re;
    logic [ADDR_W-1:0]    seq_addr;
    logic [1:0]           seq_data;
    logic                 done;
    logic                 found_it;
    logic                 error;
    logic [ADDR_W-1:0]    match_pos;
`ifdef DNA_SEARCH_COUNT_EN
    logic [CNT_W-1:0]     match_count;
`endif

    dna_stream_search #(
        .ADDR_W  (ADDR_W),
        .MAX_PAT (MAX_PAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ready      (ready),
        .dna_start  (dna_start),
        .dna_length (dna_length),
        .pattern    (pattern),
        .pat_len    (pat_len),
        .seq_re     (seq_re),
        .seq_addr   (seq_addr),
        .seq_data   (seq_data),
        .done       (done),
        .found_it   (found_it),
        .error      (error),
        .match_pos  (match_pos)
`ifdef DNA_SEARCH_COUNT_EN
        ,
        .match_count(match_count)
`endif
    );

    always #5 clock = ~clock;

    // Sequence memory with one cycle of read latency.
    logic [1:0] mem [0:65535];
    always @(posedge clock) if (seq_re) seq_data <= mem[seq_addr];

    typedef struct {
        logic [ADDR_W-1:0]    start;
        logic [ADDR_W-1:0]    len;
        logic [2*MAX_PAT-1:0] pat;
        logic [PL_W-1:0]      plen;
        bit                   exp_err;
        bit                   exp_found;
        logic [ADDR_W-1:0]    exp_pos;
        int                   exp_i;    // index of the nucleotide completing the first match
        int                   exp_cnt;  // all overlapping matches
    } vec_t;

    typedef struct {
        int                done_edge;
        int                reads;
        bit                err;
        bit                found;
        logic [ADDR_W-1:0] pos;
        int                cnt;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q [$];
    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] nuc(input byte c);
        case (c)
            "A":     return 2'b00;
            "C":     return 2'b01;
            "G":     return 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [2*MAX_PAT-1:0] enc(input string s);
        logic [2*MAX_PAT-1:0] p;
        p = '0;
        for (int j = 0; j < s.len() && j < MAX_PAT; j++) p[2*j +: 2] = nuc(s[j]);
        return p;
    endfunction

    task automatic load(input int addr, input string s);
        for (int k = 0; k < s.len(); k++) mem[16'(addr + k)] = nuc(s[k]);
    endtask

    // Launch one search, push its expectation, follow it edge by edge, then score it.
    task automatic run_vec(input vec_t v, input int poke_at, input string tag);
        exp_t e;
        exp_t got;
        int   k;
        int   reads;
        bit   addr_bad;
        bit   seen;

        e.err   = v.exp_err;
        e.found = v.exp_found && !v.exp_err;
        e.pos   = v.exp_pos;
        e.cnt   = v.exp_cnt;
        if (v.exp_err) begin
            e.done_edge = 0;
            e.reads     = 0;
        end else if (COUNT_EN || !v.exp_found) begin
            e.done_edge = int'(v.len) + 1;
            e.reads     = int'(v.len);
        end else begin
            e.done_edge = v.exp_i + 2;
            e.reads     = (v.exp_i + 2 < int'(v.len)) ? v.exp_i + 2 : int'(v.len);
        end
        exp_q.push_back(e);

        @(negedge clock);
        ready      = 1'b1;
        dna_start  = v.start;
        dna_length = v.len;
        pattern    = v.pat;
        pat_len    = v.plen;
        @(negedge clock);
        // Edge 0 has been taken; scramble the request ports, which the DUT must ignore now.
        ready      = 1'b0;
        dna_start  = 16'($urandom);
        dna_length = 16'($urandom);
        pattern    = 16'($urandom);
        pat_len    = 4'($urandom_range(0, 15));
        if (!v.exp_err) begin
            check({tag, "_cleared"}, {done, found_it, error, match_pos}, '0);
`ifdef DNA_SEARCH_COUNT_EN
            check({tag, "_cnt_cleared"}, match_count, '0);
`endif
        end

        k = 0; reads = 0; addr_bad = 1'b0; seen = 1'b0;
        while (k <= int'(v.len) + 8) begin
            if (seq_re) begin
                if (seq_addr !== 16'(v.start + reads)) addr_bad = 1'b1;
                reads++;
            end
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (k == poke_at) begin
                ready      = 1'b1;
                dna_start  = 16'h0300;
                dna_length = 16'd2;
                pattern    = enc("CC");
                pat_len    = 4'd2;
            end
            @(negedge clock);
            ready = 1'b0;
            k++;
        end

        got = exp_q.pop_front();
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done not seen within %0d edges, expected at edge %0d", tag, k, got.done_edge);
            return;
        end
        check({tag, "_done_edge"}, k, got.done_edge);
        check({tag, "_error"}, error, got.err);
        check({tag, "_found"}, found_it, got.found);
        check({tag, "_pos"}, match_pos, got.pos);
        check({tag, "_reads"}, reads, got.reads);
        check({tag, "_addr_seq_bad"}, addr_bad, 0);
`ifdef DNA_SEARCH_COUNT_EN
        check({tag, "_count"}, match_count, got.cnt);
`endif
        repeat (2) @(negedge clock);
        check({tag, "_held"}, {done, seq_re, found_it}, {2'b10, got.found});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 2'($urandom);
        load(32'h0100, "ACGTACGT");
        load(32'h0200, "AAAAA");
        load(32'h0300, "CCCCAT");
        load(32'hFFFC, "GGTA");

        //          start     len    pattern           plen  err found pos       i  cnt
        vecs[0]  = '{16'h0100, 16'd8, enc("GTA"),      4'd3, 0, 1, 16'h0102, 4, 1};
        vecs[1]  = '{16'h0100, 16'd8, enc("TTT"),      4'd3, 0, 0, 16'h0000, 0, 0};
        vecs[2]  = '{16'h0100, 16'd8, enc("ACGTACGT"), 4'd8, 0, 1, 16'h0100, 7, 1};
        vecs[3]  = '{16'h0100, 16'd8, enc("A"),        4'd1, 0, 1, 16'h0100, 0, 2};
        vecs[4]  = '{16'h0100, 16'd8, enc("CG"),       4'd2, 0, 1, 16'h0101, 2, 2};
        vecs[5]  = '{16'h0100, 16'd8, enc("AA"),       4'd2, 0, 0, 16'h0000, 0, 0};
        vecs[6]  = '{16'h0300, 16'd6, enc("AT"),       4'd2, 0, 1, 16'h0304, 5, 1};
        vecs[7]  = '{16'h0300, 16'd2, enc("CC"),       4'd2, 0, 1, 16'h0300, 1, 1};
        vecs[8]  = '{16'hFFFC, 16'd4, enc("TA"),       4'd2, 0, 1, 16'hFFFE, 3, 1};
        vecs[9]  = '{16'h0200, 16'd5, enc("AA"),       4'd2, 0, 1, 16'h0200, 1, 4};
        vecs[10] = '{16'h0100, 16'd8, enc("GTA"),      4'd0, 1, 0, 16'h0000, 0, 0};
        vecs[11] = '{16'h0100, 16'd8, enc("ACGTACGT"), 4'd9, 1, 0, 16'h0000, 0, 0};
        vecs[12] = '{16'h0100, 16'd4, enc("ACGTA"),    4'd5, 1, 0, 16'h0000, 0, 0};
        vecs[13] = '{16'hFFFE, 16'd4, enc("TA"),       4'd2, 1, 0, 16'h0000, 0, 0};

        repeat (3) @(negedge clock);
        check("reset_outputs", {seq_re, done, found_it, error, match_pos}, '0);
`ifdef DNA_SEARCH_COUNT_EN
        check("reset_count", match_count, '0);
`endif
        reset = 1'b0;

        // Each run after the first is accepted from DONE.
        for (int n = 0; n < 14; n++) run_vec(vecs[n], -1, $sformatf("v%0d", n));

        // Reset in the middle of a run, then rerun from IDLE.
        @(negedge clock);
        ready      = 1'b1;
        dna_start  = 16'h0100;
        dna_length = 16'd8;
        pattern    = enc("GTA");
        pat_len    = 4'd3;
        @(negedge clock);
        ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_mid_outputs", {seq_re, done, found_it, error, match_pos}, '0);
        reset = 1'b0;
        @(negedge clock);
        check("rst_mid_idle", {seq_re, done}, 2'b00);
        run_vec(vecs[0], -1, "rerun");

        // A ready pulse during RUN carrying a different valid request must be ignored.
        run_vec(vecs[1], 2, "poke");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
